// File: rtl/srlatch_sequencer_pkg.sv
// Shared encodings for the SR latch sequencer: FSM states, grant values and counter sizing.
package srlatch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // A grant value doubles as the commanded latch state (set -> Q=1, reset -> Q=0).
    localparam logic GRANT_SET = 1'b1;
    localparam logic GRANT_RST = 1'b0;

    function automatic int cnt_width(input int pulse_cycles, input int gap_cycles);
        int m;
        m = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/srlatch_sequencer_sync2.sv
// Generic two-flop synchronizer with synchronous active-low reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/srlatch_sequencer.sv
// Arbitrates set/reset requests into non-overlapping S/R pulses for an external NOR latch
// and verifies the latch readback after each pulse.
//
// state  | meaning
// IDLE   | waiting for a request; grants, or acknowledges a redundant one without pulsing
// DRIVE  | S or R pulse in progress (outputs lag the state by one register stage)
// SETTLE | S and R low; Q readback compared in the last cycle
module srlatch_sequencer
    import srlatch_sequencer_pkg::*;
#(
    parameter int PULSE_CYCLES   = 2,
    parameter int GAP_CYCLES     = 3,
    parameter bit SKIP_REDUNDANT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    output logic set_ack,
    output logic rst_ack,
    output logic s_out,
    output logic r_out,
    input  logic q_in,
    output logic busy,
    output logic done,
    output logic fault,
    input  logic fault_clr
);

    localparam int              CNT_W      = cnt_width(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             target_q, target_d;
    logic             last_grant_q, last_grant_d;
    logic             done_pend_q, done_pend_d;
    logic             set_ack_d, rst_ack_d;
    logic             fault_set;
    logic             grant_valid;
    logic             grant;
    logic             q_sync;

    sync2 #(.WIDTH(1)) u_q_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (q_in),
        .q     (q_sync)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        last_grant_d = last_grant_q;
        done_pend_d  = 1'b0;
        set_ack_d    = 1'b0;
        rst_ack_d    = 1'b0;
        fault_set    = 1'b0;
        grant_valid  = 1'b0;
        grant        = GRANT_SET;

        case (state_q)
            IDLE: begin
                if (set_req && rst_req) begin
                    grant_valid = 1'b1;
                    grant       = (last_grant_q == GRANT_RST) ? GRANT_SET : GRANT_RST;
                end else if (set_req) begin
                    grant_valid = 1'b1;
                    grant       = GRANT_SET;
                end else if (rst_req) begin
                    grant_valid = 1'b1;
                    grant       = GRANT_RST;
                end

                if (grant_valid) begin
                    set_ack_d    = (grant == GRANT_SET);
                    rst_ack_d    = (grant == GRANT_RST);
                    target_d     = grant;
                    last_grant_d = grant;
                    if (SKIP_REDUNDANT && (q_sync == grant)) begin
                        done_pend_d = 1'b1;
                    end else begin
                        state_d = DRIVE;
                        cnt_d   = PULSE_LOAD;
                    end
                end
            end

            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    done_pend_d = 1'b1;
                    fault_set   = (q_sync != target_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // done goes through done_pend so a skipped command reports one cycle after its ack
    // and a driven command reports on the cycle after the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            target_q     <= GRANT_RST;
            last_grant_q <= GRANT_RST;
            done_pend_q  <= 1'b0;
            done         <= 1'b0;
            set_ack      <= 1'b0;
            rst_ack      <= 1'b0;
            s_out        <= 1'b0;
            r_out        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            last_grant_q <= last_grant_d;
            done_pend_q  <= done_pend_d;
            done         <= done_pend_q;
            set_ack      <= set_ack_d;
            rst_ack      <= rst_ack_d;
            s_out        <= (state_q == DRIVE) && target_q;
            r_out        <= (state_q == DRIVE) && !target_q;
            if (fault_set) begin
                fault <= 1'b1;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_srlatch_sequencer.sv
// Scoreboard bench for srlatch_sequencer driving a behavioural NOR SR latch.
module tb_srlatch_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic rst_req = 1'b0;
    logic fault_clr = 1'b0;
    logic set_ack, rst_ack, s_out, r_out, busy, done, fault;
    logic q_in;
    logic latch_q = 1'b0;
    logic force_q0 = 1'b0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [2:0] ev;   // {set_ack, rst_ack, done}
    } exp_t;
    exp_t exp_q[$];

    srlatch_sequencer #(
        .PULSE_CYCLES   (2),
        .GAP_CYCLES     (3),
        .SKIP_REDUNDANT (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_req   (set_req),
        .rst_req   (rst_req),
        .set_ack   (set_ack),
        .rst_ack   (rst_ack),
        .s_out     (s_out),
        .r_out     (r_out),
        .q_in      (q_in),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .fault_clr (fault_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // NOR latch: S sets, R resets, both low holds
    always @(s_out or r_out) begin
        if (s_out && !r_out) latch_q = 1'b1;
        else if (r_out && !s_out) latch_q = 1'b0;
    end

    assign q_in = force_q0 ? 1'b0 : latch_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        exp_q.push_back(e);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t || clk != 1'b0) @(negedge clk);
    endtask

    task automatic issue(input bit s, input bit r, output int c0);
        @(posedge clk);
        #1;
        set_req = s;
        rst_req = r;
        c0 = cyc;
        @(posedge clk);
        #1;
        set_req = 1'b0;
        rst_req = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [2:0] ev;
        exp_t       e;
        if (mon_en) begin
            check("s_r_exclusive", 32'(s_out & r_out), 32'd0);
            ev = {set_ack, rst_ack, done};
            if (ev != 3'b000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got ev=%b at cycle %0d, expected none", ev, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (ev !== e.ev || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL scoreboard_event: got ev=%b cyc=%0d expected ev=%b cyc=%0d",
                                 ev, cyc, e.ev, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;

        // reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({s_out, r_out, set_ack, rst_ack, busy, done, fault}), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // single set from Q=0: ack@1, S high @2-3, gap @4-6, done@7
        issue(1'b1, 1'b0, c);
        push(c + 1, 3'b100);
        push(c + 7, 3'b001);
        for (int k = 1; k <= 7; k++) begin
            at_cyc(c + k);
            check("t1_s_out", 32'(s_out), 32'((k == 2) || (k == 3)));
            check("t1_r_out", 32'(r_out), 32'd0);
            check("t1_busy", 32'(busy), 32'(k <= 5));
        end
        check("t1_fault", 32'(fault), 32'd0);
        check("t1_latch_q", 32'(latch_q), 32'd1);

        // redundant set with Q=1: ack then done next cycle, no pulse, never busy
        issue(1'b1, 1'b0, c);
        push(c + 1, 3'b100);
        push(c + 2, 3'b001);
        for (int k = 1; k <= 4; k++) begin
            at_cyc(c + k);
            check("t3_s_out", 32'(s_out), 32'd0);
            check("t3_busy", 32'(busy), 32'd0);
        end

        // single reset to bring Q back to 0
        issue(1'b0, 1'b1, c);
        push(c + 1, 3'b010);
        push(c + 7, 3'b001);
        at_cyc(c + 8);
        check("rst_latch_q", 32'(latch_q), 32'd0);

        // both requests held: set, reset, set with acks 6 cycles apart
        @(posedge clk);
        #1;
        set_req = 1'b1;
        rst_req = 1'b1;
        c = cyc;
        push(c + 1, 3'b100);
        push(c + 7, 3'b011);
        push(c + 13, 3'b101);
        push(c + 19, 3'b001);
        for (int k = 1; k <= 20; k++) begin
            at_cyc(c + k);
            if (k == 14) begin
                set_req = 1'b0;
                rst_req = 1'b0;
            end
            if (k == 6)  check("t2_q_after_set", 32'(latch_q), 32'd1);
            if (k == 12) check("t2_q_after_rst", 32'(latch_q), 32'd0);
            if (k == 18) check("t2_q_after_set2", 32'(latch_q), 32'd1);
        end

        // readback stuck at 0: full pulse then sticky fault, cleared by fault_clr
        force_q0 = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b1, 1'b0, c);
        push(c + 1, 3'b100);
        push(c + 7, 3'b001);
        at_cyc(c + 3);
        check("t4_s_out", 32'(s_out), 32'd1);
        at_cyc(c + 5);
        check("t4_fault_before", 32'(fault), 32'd0);
        at_cyc(c + 6);
        check("t4_fault_set", 32'(fault), 32'd1);
        at_cyc(c + 9);
        check("t4_fault_sticky", 32'(fault), 32'd1);
        fault_clr = 1'b1;
        at_cyc(c + 10);
        fault_clr = 1'b0;
        check("t4_fault_cleared", 32'(fault), 32'd0);

        // fault_clr on the same edge as a new mismatch: set wins
        issue(1'b1, 1'b0, c);
        push(c + 1, 3'b100);
        push(c + 7, 3'b001);
        at_cyc(c + 5);
        fault_clr = 1'b1;
        at_cyc(c + 6);
        fault_clr = 1'b0;
        check("t4_set_beats_clr", 32'(fault), 32'd1);
        at_cyc(c + 8);
        fault_clr = 1'b1;
        at_cyc(c + 9);
        fault_clr = 1'b0;
        check("t4_fault_cleared2", 32'(fault), 32'd0);
        force_q0 = 1'b0;
        at_cyc(c + 14);

        // reset request raised mid-SETTLE: no ack until back in IDLE
        issue(1'b0, 1'b1, c);
        push(c + 1, 3'b010);
        at_cyc(c + 4);
        rst_req = 1'b1;
        push(c + 7, 3'b011);
        push(c + 8, 3'b001);
        at_cyc(c + 5);
        check("t6_no_ack_busy", 32'(rst_ack), 32'd0);
        at_cyc(c + 6);
        check("t6_no_ack_busy2", 32'(rst_ack), 32'd0);
        at_cyc(c + 7);
        rst_req = 1'b0;
        check("t6_latch_q", 32'(latch_q), 32'd0);
        at_cyc(c + 10);

        // reset during DRIVE: S drops on that edge, command abandoned without done
        issue(1'b1, 1'b0, c);
        push(c + 1, 3'b100);
        at_cyc(c + 3);
        check("t5_s_out_high", 32'(s_out), 32'd1);
        rst_n = 1'b0;
        at_cyc(c + 4);
        rst_n = 1'b1;
        check("t5_s_out_dropped", 32'(s_out), 32'd0);
        check("t5_busy_dropped", 32'(busy), 32'd0);
        at_cyc(c + 12);
        check("t5_latch_q", 32'(latch_q), 32'd1);

        // first tie after reset goes to set (redundant here since Q=1)
        issue(1'b1, 1'b1, c);
        push(c + 1, 3'b100);
        push(c + 2, 3'b001);
        at_cyc(c + 4);

        // reset request after reset accepted normally
        issue(1'b0, 1'b1, c);
        push(c + 1, 3'b010);
        push(c + 7, 3'b001);
        at_cyc(c + 4);
        check("t5_r_busy", 32'(busy), 32'd1);
        at_cyc(c + 10);
        check("t5_rst_latch_q", 32'(latch_q), 32'd0);
        check("t5_fault", 32'(fault), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
